// File: rtl/text_window_render.sv
// Glyph-bitmap window overlay: maps a screen rectangle onto a 1-bpp bitmap held in
// an external synchronous ROM and emits one RGB888 pixel per lcd_clk.
module text_window_render #(
  parameter int unsigned WIN_X     = 1,
  parameter int unsigned WIN_Y     = 1,
  parameter int unsigned BMP_W     = 256,
  parameter int unsigned BMP_H     = 64,
  parameter int unsigned SCALE     = 1,
  parameter int unsigned ROM_AW    = 12,
  parameter int unsigned ROM_DW    = 32,
  parameter int unsigned ROM_LAT   = 1,
  parameter logic [23:0] OUT_COLOR = 24'h000000
) (
  input  logic              lcd_clk,
  input  logic              sys_rst,
  input  logic [10:0]       x_pos,
  input  logic [10:0]       y_pos,
  input  logic              de,
  input  logic [ROM_AW-1:0] lrom_offset,
  input  logic [23:0]       fg_color,
  input  logic [23:0]       bg_color,
  input  logic              invert,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_data,
  output logic [23:0]       pixel_data,
  output logic              pixel_de,
  output logic              win_active
);

  localparam int unsigned SH = $clog2(SCALE);
  localparam int unsigned IW = $clog2(ROM_DW);
  // 12-bit bounds so a window reaching past column 2047 cannot wrap to low x
  localparam logic [11:0] X0 = 12'(WIN_X);
  localparam logic [11:0] X1 = 12'(WIN_X + BMP_W * SCALE);
  localparam logic [11:0] Y0 = 12'(WIN_Y);
  localparam logic [11:0] Y1 = 12'(WIN_Y + BMP_H * SCALE);
  localparam logic [ROM_AW-1:0] WPR = ROM_AW'(BMP_W / ROM_DW);

  logic [11:0]       w_x;
  logic [11:0]       w_y;
  logic [11:0]       w_bx;
  logic [11:0]       w_by;
  logic              w_inside;
  logic [ROM_AW-1:0] w_addr;
  logic [IW-1:0]     w_idx;

  logic [ROM_AW-1:0] r_off;
  logic [ROM_LAT:0]  r_vld;
  logic [ROM_LAT:0]  r_inside;
  logic [ROM_LAT:0]  r_de;
  logic [IW-1:0]     r_idx [ROM_LAT+1];

  assign w_x      = {1'b0, x_pos};
  assign w_y      = {1'b0, y_pos};
  assign w_inside = (w_x >= X0) && (w_x < X1) && (w_y >= Y0) && (w_y < Y1);
  assign w_bx     = (w_x - X0) >> SH;
  assign w_by     = (w_y - Y0) >> SH;
  assign w_addr   = r_off + ROM_AW'(w_by) * WPR + ROM_AW'(w_bx / 12'(ROM_DW));
  assign w_idx    = IW'(ROM_DW - 1) - IW'(w_bx % 12'(ROM_DW));

  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_off    <= '0;
      rom_addr <= '0;
      r_vld    <= '0;
      r_inside <= '0;
      r_de     <= '0;
    end else begin
      // offset is only taken at frame start so a frame never mixes two offsets
      if (!de && (x_pos == '0) && (y_pos == '0)) r_off <= lrom_offset;
      if (w_inside) rom_addr <= w_addr;
      r_vld    <= {r_vld[ROM_LAT-1:0], 1'b1};
      r_inside <= {r_inside[ROM_LAT-1:0], w_inside};
      r_de     <= {r_de[ROM_LAT-1:0], de};
    end
  end

  always_ff @(posedge lcd_clk) begin
    r_idx[0] <= w_idx;
    for (int i = 1; i <= ROM_LAT; i++) r_idx[i] <= r_idx[i-1];
  end

  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pixel_data <= OUT_COLOR;
      pixel_de   <= 1'b0;
      win_active <= 1'b0;
    end else if (r_vld[ROM_LAT]) begin
      pixel_de   <= r_de[ROM_LAT];
      win_active <= r_inside[ROM_LAT];
      if (!r_inside[ROM_LAT])                     pixel_data <= OUT_COLOR;
      else if (rom_data[r_idx[ROM_LAT]] ^ invert) pixel_data <= fg_color;
      else                                        pixel_data <= bg_color;
    end
  end

endmodule

// File: tb/tb_text_window_render.sv
// Scoreboard bench: four DUT configurations share one pixel stream; each has its own
// ROM model, expected-value queue and monitor.
module tb_text_window_render;

  typedef struct packed {
    logic [31:0] tag;
    logic        bv;
    logic        ins;
    logic        de;
  } exp_t;

  localparam int          P_WX  [4] = '{1, 1, 1, 2040};
  localparam int          P_BW  [4] = '{256, 256, 64, 256};
  localparam int          P_BH  [4] = '{64, 64, 16, 64};
  localparam int          P_SC  [4] = '{1, 1, 2, 1};
  localparam int          P_LAT [4] = '{1, 3, 2, 1};
  localparam logic [23:0] P_OC  [4] = '{24'h000000, 24'h000000, 24'h0F0F0F, 24'h000000};
  // window pixels seen in one full frame scan: 256x64, 256x64, 128x32, 8 columns x 64
  localparam int          P_WIN [4] = '{16384, 16384, 4096, 512};

  logic        lcd_clk;
  logic        sys_rst;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic        de;
  logic [11:0] lrom_offset;
  logic [23:0] fg_color;
  logic [23:0] bg_color;
  logic        invert;

  int          pat;
  int unsigned cyc;
  int unsigned fr_t0;
  int          checks;
  int          errors;
  int          w_cnt [4];

  initial lcd_clk = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge lcd_clk);
      #1 cyc++;
    end
  end

  function automatic logic [31:0] rom_word(input logic [11:0] a, input int p);
    if (p == 1) return a[3] ? 32'hAAAA_AAAA : 32'h5555_5555;
    if (a == 12'd0) return 32'h8000_0001;
    if (a == 12'd16) return 32'hFFFF_0000;
    return {a, ~a, 8'hC3};
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h at %0t", nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int          WX  = P_WX[g];
    localparam int          BW  = P_BW[g];
    localparam int          BH  = P_BH[g];
    localparam int          SC  = P_SC[g];
    localparam int          LAT = P_LAT[g];
    localparam logic [23:0] OC  = P_OC[g];

    logic [11:0] rom_addr;
    logic [31:0] rom_data;
    logic [23:0] pixel_data;
    logic        pixel_de;
    logic        win_active;
    logic [31:0] rq [0:2];
    exp_t        q [$];
    int          m_off;

    text_window_render #(
      .WIN_X(WX), .WIN_Y(1), .BMP_W(BW), .BMP_H(BH), .SCALE(SC),
      .ROM_AW(12), .ROM_DW(32), .ROM_LAT(LAT), .OUT_COLOR(OC)
    ) u_dut (
      .lcd_clk     (lcd_clk),
      .sys_rst     (sys_rst),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .de          (de),
      .lrom_offset (lrom_offset),
      .fg_color    (fg_color),
      .bg_color    (bg_color),
      .invert      (invert),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .pixel_data  (pixel_data),
      .pixel_de    (pixel_de),
      .win_active  (win_active)
    );

    // synchronous ROM with LAT clocks of read latency
    always @(posedge lcd_clk) begin
      rq[0] <= rom_word(rom_addr, pat);
      for (int i = 1; i < 3; i++) rq[i] <= rq[i-1];
    end
    assign rom_data = rq[LAT-1];

    initial begin : push
      int          xi, yi, bx, by;
      logic [11:0] a;
      logic [31:0] w;
      logic        ins, bv;
      m_off = 0;
      forever begin
        @(posedge lcd_clk);
        if (!sys_rst) begin
          q.delete();
          m_off = 0;
        end else begin
          xi  = int'(x_pos);
          yi  = int'(y_pos);
          ins = (xi >= WX) && (xi < WX + BW * SC) && (yi >= 1) && (yi < 1 + BH * SC);
          bv  = 1'b0;
          if (ins) begin
            bx = (xi - WX) / SC;
            by = (yi - 1) / SC;
            a  = 12'(m_off + by * (BW / 32) + bx / 32);
            w  = rom_word(a, pat);
            bv = w[31 - (bx % 32)];
          end
          q.push_back('{tag: cyc, bv: bv, ins: ins, de: de});
          if (!de && x_pos == 11'd0 && y_pos == 11'd0) m_off = int'(lrom_offset);
        end
      end
    end

    initial begin : mon
      exp_t        e;
      logic [23:0] ep;
      logic        hold;
      hold     = 1'b1;
      w_cnt[g] = 0;
      forever begin
        @(negedge lcd_clk);
        if (!sys_rst) begin
          hold = 1'b1;
          chk("rst_pix", g, {8'h0, pixel_data}, {8'h0, OC});
          chk("rst_de", g, {31'h0, pixel_de}, 32'h0);
          chk("rst_win", g, {31'h0, win_active}, 32'h0);
          chk("rst_addr", g, {20'h0, rom_addr}, 32'h0);
        end else if (q.size() != 0 && q[0].tag + LAT + 2 == cyc) begin
          e    = q.pop_front();
          hold = 1'b0;
          ep   = !e.ins ? OC : ((e.bv ^ invert) ? fg_color : bg_color);
          chk("pix", g, {8'h0, pixel_data}, {8'h0, ep});
          chk("pde", g, {31'h0, pixel_de}, {31'h0, e.de});
          chk("win", g, {31'h0, win_active}, {31'h0, e.ins});
          if (e.tag >= fr_t0 && win_active) w_cnt[g]++;
        end else if (hold) begin
          chk("hold_pix", g, {8'h0, pixel_data}, {8'h0, OC});
          chk("hold_win", g, {31'h0, win_active}, 32'h0);
        end
      end
    end
  end

  task automatic pix(input int x, input int y, input logic d);
    @(posedge lcd_clk);
    #2;
    x_pos = 11'(x);
    y_pos = 11'(y);
    de    = d;
  endtask

  task automatic gap(input int n);
    repeat (n) pix(1500, 100, 1'b0);
  endtask

  task automatic line(input int y, input logic d);
    for (int x = 0; x <= 258; x++) pix(x, y, d);
    for (int x = 2030; x <= 2047; x++) pix(x, y, d);
    gap(2);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    fr_t0       = 32'hFFFF_FFFF;
    pat         = 0;
    sys_rst     = 1'b0;
    x_pos       = '0;
    y_pos       = '0;
    de          = 1'b0;
    lrom_offset = 12'd0;
    fg_color    = 24'h123456;
    bg_color    = 24'hA55A0F;
    invert      = 1'b0;
    repeat (4) @(posedge lcd_clk);
    #2 sys_rst = 1'b1;

    // frame 1: offset moves to 16 mid-frame but must not take effect yet
    pix(0, 0, 1'b0);
    line(1, 1'b1);
    lrom_offset = 12'd16;
    line(2, 1'b1);
    line(3, 1'b0);
    gap(8);
    invert   = 1'b1;
    fg_color = 24'hFF00FF;

    // frame 2: row 0 now reads from word 16, colours swapped
    pix(0, 0, 1'b0);
    line(1, 1'b1);
    line(2, 1'b1);
    for (int x = 0; x <= 258; x++) begin
      @(posedge lcd_clk);
      #2;
      sys_rst = (x != 100);
      x_pos   = 11'(x);
      y_pos   = 11'd3;
      de      = 1'b1;
    end
    gap(8);

    // full checkerboard frame
    invert      = 1'b0;
    pat         = 1;
    lrom_offset = 12'd0;
    gap(2);
    fr_t0 = cyc;
    pix(0, 0, 1'b0);
    for (int y = 0; y <= 65; y++) line(y, 1'b1);
    gap(10);

    for (int g = 0; g < 4; g++) chk("win_cnt", g, w_cnt[g], P_WIN[g]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
